// File: rtl/coo_stream_matmul_if.sv
// Stream bundle for coo_stream_matmul: Y load, COO triplet input and result output.
// The err signal exists only when COO_STREAM_BOUNDS_CHECK_EN is defined.
interface coo_stream_matmul_if #(
   parameter int N          = 4,
   parameter int M          = 4,
   parameter int K          = 4,
   parameter int X_WIDTH    = 8,
   parameter int Y_WIDTH    = 8,
   parameter int ADDR_WIDTH = 16,
   parameter int OUT_WIDTH  = 16,
   parameter int MAX_NZN    = 16
);
   localparam int CNT_WIDTH = $clog2(MAX_NZN + 1);

   logic [M*K-1:0][Y_WIDTH-1:0]   y_data;
   logic                          y_valid;
   logic                          y_ready;
   logic [X_WIDTH-1:0]            x_data;
   logic [ADDR_WIDTH-1:0]         x_row;
   logic [ADDR_WIDTH-1:0]         x_col;
   logic                          x_last;
   logic                          x_valid;
   logic                          x_ready;
   logic [N*K-1:0][OUT_WIDTH-1:0] out_data;
   logic [CNT_WIDTH-1:0]          out_nnz;
   logic                          out_valid;
   logic                          out_ready;
`ifdef COO_STREAM_BOUNDS_CHECK_EN
   logic                          err;
`endif

   modport master (
      output y_data, y_valid, x_data, x_row, x_col, x_last, x_valid, out_ready,
      input  y_ready, x_ready, out_data, out_nnz, out_valid
`ifdef COO_STREAM_BOUNDS_CHECK_EN
      , input err
`endif
   );

   modport slave (
      input  y_data, y_valid, x_data, x_row, x_col, x_last, x_valid, out_ready,
      output y_ready, x_ready, out_data, out_nnz, out_valid
`ifdef COO_STREAM_BOUNDS_CHECK_EN
      , output err
`endif
   );
endinterface

// File: rtl/coo_stream_matmul.sv
// Streaming sparse(COO) x dense matmul: one nonzero of X per cycle updates a full output row.
// Optional range checking and sticky err flag via macro COO_STREAM_BOUNDS_CHECK_EN.
module coo_stream_matmul #(
   parameter int N               = 4,
   parameter int M               = 4,
   parameter int K               = 4,
   parameter int X_WIDTH         = 8,
   parameter int X_FRAC_WIDTH    = 1,
   parameter int Y_WIDTH         = 8,
   parameter int Y_FRAC_WIDTH    = 1,
   parameter int MAX_NZN         = 16,
   parameter int ADDR_WIDTH      = 16,
   parameter int OUTPUT_ROUNDING = 1,
   parameter int OUT_WIDTH       = 16,
   parameter int OUT_FRAC_WIDTH  = 0
) (
   input  logic               clk,
   input  logic               rst,
   coo_stream_matmul_if.slave bus
);
   localparam int ACC_WIDTH      = X_WIDTH + Y_WIDTH + $clog2(MAX_NZN);
   localparam int ACC_FRAC_WIDTH = X_FRAC_WIDTH + Y_FRAC_WIDTH;
   localparam int CNT_WIDTH      = $clog2(MAX_NZN + 1);
   localparam int ROW_WIDTH      = (N > 1) ? $clog2(N) : 1;
   localparam int COL_WIDTH      = (M > 1) ? $clog2(M) : 1;
   localparam int PROD_WIDTH     = X_WIDTH + Y_WIDTH;

   localparam int SHR     = ACC_FRAC_WIDTH - OUT_FRAC_WIDTH;
   localparam int SHR_AMT = (SHR > 0) ? SHR : 0;
   localparam int SHL_AMT = (SHR < 0) ? -SHR : 0;
   localparam int RW      = ACC_WIDTH + SHL_AMT + OUT_WIDTH + 1;
   localparam logic signed [RW-1:0] HALF =
      (SHR > 0) ? (RW'(1) <<< ((SHR_AMT > 0) ? SHR_AMT - 1 : 0)) : RW'(0);
   localparam logic signed [RW-1:0] OUT_MAX = (RW'(1) <<< (OUT_WIDTH - 1)) - RW'(1);
   localparam logic signed [RW-1:0] OUT_MIN = -OUT_MAX - RW'(1);

   if (OUTPUT_ROUNDING == 0 &&
       (OUT_WIDTH != ACC_WIDTH || OUT_FRAC_WIDTH != ACC_FRAC_WIDTH)) begin : g_bad_raw_cfg
      $fatal(1, "raw output requires OUT_WIDTH/OUT_FRAC_WIDTH equal to the accumulator format");
   end

   typedef enum logic [1:0] {WAIT_Y, ACCUM, OUTPUT} state_t;

   state_t                        state;
   logic signed [ACC_WIDTH-1:0]   acc   [N][K];
   logic signed [Y_WIDTH-1:0]     y_reg [M][K];
   logic [CNT_WIDTH-1:0]          nnz;
   logic [ROW_WIDTH-1:0]          row_idx;
   logic [COL_WIDTH-1:0]          col_idx;
   logic                          in_range;
   logic signed [ACC_WIDTH-1:0]   prod  [K];
   logic [N*K-1:0][OUT_WIDTH-1:0] out_flat;

   assign row_idx = bus.x_row[ROW_WIDTH-1:0];
   assign col_idx = bus.x_col[COL_WIDTH-1:0];

`ifdef COO_STREAM_BOUNDS_CHECK_EN
   assign in_range = (bus.x_row < ADDR_WIDTH'(N)) && (bus.x_col < ADDR_WIDTH'(M));
`else
   logic unused_idx_bits;
   assign in_range        = 1'b1;
   assign unused_idx_bits = ^{bus.x_row[ADDR_WIDTH-1:ROW_WIDTH], bus.x_col[ADDR_WIDTH-1:COL_WIDTH]};
`endif

   // Round half toward +inf, then saturate into the output format.
   function automatic logic [OUT_WIDTH-1:0] round_acc(input logic signed [ACC_WIDTH-1:0] a);
      logic signed [RW-1:0] v;
      v = RW'(a);
      v = (v <<< SHL_AMT) + HALF;
      v = v >>> SHR_AMT;
      if (v > OUT_MAX)
         v = OUT_MAX;
      else if (v < OUT_MIN)
         v = OUT_MIN;
      return v[OUT_WIDTH-1:0];
   endfunction

   always_comb begin
      logic signed [PROD_WIDTH-1:0] xe;
      logic signed [PROD_WIDTH-1:0] ye;
      logic signed [PROD_WIDTH-1:0] p;
      xe = {{Y_WIDTH{bus.x_data[X_WIDTH-1]}}, bus.x_data};
      for (int k = 0; k < K; k++) begin
         ye      = {{X_WIDTH{y_reg[col_idx][k][Y_WIDTH-1]}}, y_reg[col_idx][k]};
         p       = xe * ye;
         prod[k] = ACC_WIDTH'(p);
      end
   end

   always_comb begin
      out_flat = '0;
      for (int n = 0; n < N; n++) begin
         for (int k = 0; k < K; k++) begin
            if (OUTPUT_ROUNDING != 0)
               out_flat[n*K+k] = round_acc(acc[n][k]);
            else
               out_flat[n*K+k] = OUT_WIDTH'(acc[n][k]);
         end
      end
   end

   assign bus.out_data = out_flat;
   assign bus.out_nnz  = nnz;

   // Ready/valid flags are registered alongside the state so they are glitch-free per state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= WAIT_Y;
         bus.y_ready   <= 1'b1;
         bus.x_ready   <= 1'b0;
         bus.out_valid <= 1'b0;
         nnz           <= '0;
`ifdef COO_STREAM_BOUNDS_CHECK_EN
         bus.err       <= 1'b0;
`endif
         for (int n = 0; n < N; n++)
            for (int k = 0; k < K; k++)
               acc[n][k] <= '0;
         for (int m = 0; m < M; m++)
            for (int k = 0; k < K; k++)
               y_reg[m][k] <= '0;
      end else begin
         case (state)
            WAIT_Y: begin
               if (bus.y_valid) begin
                  for (int m = 0; m < M; m++)
                     for (int k = 0; k < K; k++)
                        y_reg[m][k] <= bus.y_data[m*K+k];
                  bus.y_ready <= 1'b0;
                  bus.x_ready <= 1'b1;
                  state       <= ACCUM;
               end
            end
            ACCUM: begin
               if (bus.x_valid) begin
                  if (in_range) begin
                     for (int k = 0; k < K; k++)
                        acc[row_idx][k] <= acc[row_idx][k] + prod[k];
                     if (nnz != CNT_WIDTH'(MAX_NZN))
                        nnz <= nnz + CNT_WIDTH'(1);
                  end
`ifdef COO_STREAM_BOUNDS_CHECK_EN
                  if (!in_range || nnz == CNT_WIDTH'(MAX_NZN))
                     bus.err <= 1'b1;
`endif
                  if (bus.x_last) begin
                     bus.x_ready   <= 1'b0;
                     bus.out_valid <= 1'b1;
                     state         <= OUTPUT;
                  end
               end
            end
            OUTPUT: begin
               if (bus.out_ready) begin
                  for (int n = 0; n < N; n++)
                     for (int k = 0; k < K; k++)
                        acc[n][k] <= '0;
                  nnz           <= '0;
`ifdef COO_STREAM_BOUNDS_CHECK_EN
                  bus.err       <= 1'b0;
`endif
                  bus.out_valid <= 1'b0;
                  bus.y_ready   <= 1'b1;
                  state         <= WAIT_Y;
               end
            end
            default: begin
               state         <= WAIT_Y;
               bus.y_ready   <= 1'b1;
               bus.x_ready   <= 1'b0;
               bus.out_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_coo_stream_matmul.sv
// Scoreboard bench for coo_stream_matmul (2x2x2, raw accumulator output).
// Bounds test runs only when COO_STREAM_BOUNDS_CHECK_EN is defined.
module tb_coo_stream_matmul;
   localparam int N     = 2;
   localparam int M     = 2;
   localparam int K     = 2;
   localparam int XW    = 8;
   localparam int YW    = 8;
   localparam int MAXN  = 16;
   localparam int AW    = 16;
   localparam int ACC_W = XW + YW + $clog2(MAXN);
   localparam int OW    = ACC_W;
   localparam int CW    = $clog2(MAXN + 1);

   typedef struct packed {
      logic [N*K-1:0][OW-1:0] data;
      logic [CW-1:0]          nnz;
      logic                   err;
   } result_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   coo_stream_matmul_if #(
      .N(N), .M(M), .K(K), .X_WIDTH(XW), .Y_WIDTH(YW),
      .ADDR_WIDTH(AW), .OUT_WIDTH(OW), .MAX_NZN(MAXN)
   ) bus ();

   coo_stream_matmul #(
      .N(N), .M(M), .K(K),
      .X_WIDTH(XW), .X_FRAC_WIDTH(1), .Y_WIDTH(YW), .Y_FRAC_WIDTH(1),
      .MAX_NZN(MAXN), .ADDR_WIDTH(AW), .OUTPUT_ROUNDING(0),
      .OUT_WIDTH(OW), .OUT_FRAC_WIDTH(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int      checks_total  = 0;
   int      checks_passed = 0;
   bit      stall_en      = 0;
   int      ym   [M][K];
   longint  macc [N][K];
   int      mnnz;
   bit      merr;
   result_t exp_q [$];

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      checks_total++;
      if (observed === expected)
         checks_passed++;
      else
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
   endtask

   function automatic longint wrapAcc(input longint v);
      logic signed [ACC_W-1:0] t;
      t = v[ACC_W-1:0];
      return longint'(t);
   endfunction

   task automatic clearModel();
      for (int n = 0; n < N; n++)
         for (int k = 0; k < K; k++)
            macc[n][k] = 0;
      mnnz = 0;
      merr = 0;
   endtask

   task automatic setY(input int a, input int b, input int c, input int d);
      ym[0][0] = a; ym[0][1] = b; ym[1][0] = c; ym[1][1] = d;
   endtask

   task automatic loadY();
      int waited = 0;
      if (stall_en) repeat ($urandom_range(0, 2)) @(negedge clk);
      for (int m = 0; m < M; m++)
         for (int k = 0; k < K; k++)
            bus.y_data[m*K+k] = YW'(ym[m][k]);
      bus.y_valid = 1'b1;
      while (!bus.y_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 50) checkOutput("y_ready_timeout", 0, 1);
      @(negedge clk);
      bus.y_valid = 1'b0;
   endtask

   task automatic applyStimulus(input int row, input int col, input int data, input bit last);
      int      waited = 0;
      result_t r;
      if (stall_en) repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.x_row   = AW'(row);
      bus.x_col   = AW'(col);
      bus.x_data  = XW'(data);
      bus.x_last  = last;
      bus.x_valid = 1'b1;
      while (!bus.x_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 50) begin
         checkOutput("x_ready_timeout", 0, 1);
         bus.x_valid = 1'b0;
         return;
      end
      @(negedge clk);
      bus.x_valid = 1'b0;
      bus.x_last  = 1'b0;
`ifdef COO_STREAM_BOUNDS_CHECK_EN
      if (row >= N || col >= M || mnnz == MAXN) merr = 1;
`endif
      if (row < N && col < M) begin
         for (int k = 0; k < K; k++)
            macc[row][k] = wrapAcc(macc[row][k] + longint'(data) * longint'(ym[col][k]));
         if (mnnz < MAXN) mnnz++;
      end
      if (last) begin
         for (int n = 0; n < N; n++)
            for (int k = 0; k < K; k++)
               r.data[n*K+k] = OW'(macc[n][k]);
         r.nnz = CW'(mnnz);
         r.err = merr;
         exp_q.push_back(r);
         clearModel();
      end
   endtask

   task automatic collectResult(input int stall_cycles);
      int                     waited = 0;
      result_t                e;
      logic [N*K-1:0][OW-1:0] held;
      logic [CW-1:0]          held_nnz;
      while (!bus.out_valid && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("out_valid_latency", waited, 0);
      if (exp_q.size() == 0) begin
         checkOutput("result_without_stimulus", 1, 0);
         return;
      end
      e = exp_q.pop_front();
      if (!bus.out_valid) return;
      for (int i = 0; i < N*K; i++)
         checkOutput($sformatf("out_data[%0d]", i),
                     longint'($signed(bus.out_data[i])), longint'($signed(e.data[i])));
      checkOutput("out_nnz", bus.out_nnz, e.nnz);
`ifdef COO_STREAM_BOUNDS_CHECK_EN
      checkOutput("err", bus.err, e.err);
`endif
      held     = bus.out_data;
      held_nnz = bus.out_nnz;
      repeat (stall_cycles) begin
         @(negedge clk);
         checkOutput("hold_data", longint'(bus.out_data == held), 1);
         checkOutput("hold_nnz", bus.out_nnz, held_nnz);
         checkOutput("hold_out_valid", bus.out_valid, 1);
         checkOutput("hold_x_ready", bus.x_ready, 0);
         checkOutput("hold_y_ready", bus.y_ready, 0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checkOutput("post_out_valid", bus.out_valid, 0);
      checkOutput("post_y_ready", bus.y_ready, 1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.y_data    = '0;
      bus.y_valid   = 1'b0;
      bus.x_data    = '0;
      bus.x_row     = '0;
      bus.x_col     = '0;
      bus.x_last    = 1'b0;
      bus.x_valid   = 1'b0;
      bus.out_ready = 1'b0;
      rst           = 1'b0;
      clearModel();
      repeat (3) @(negedge clk);
      checkOutput("reset_out_valid", bus.out_valid, 0);
      checkOutput("reset_y_ready", bus.y_ready, 1);
      checkOutput("reset_x_ready", bus.x_ready, 0);
      checkOutput("reset_out_nnz", bus.out_nnz, 0);
      checkOutput("reset_out_data0", longint'($signed(bus.out_data[0])), 0);
      rst = 1'b1;
      @(negedge clk);

      // Basic product and duplicate accumulation
      setY(1, 2, 3, 4);
      loadY();
      applyStimulus(0, 0, 1, 0);
      applyStimulus(1, 1, 2, 1);
      collectResult(0);
      loadY();
      applyStimulus(0, 1, 1, 0);
      applyStimulus(0, 1, 1, 0);
      applyStimulus(0, 1, -1, 1);
      collectResult(0);

      // Output backpressure, then a clean second matrix
      setY(-5, 7, 9, -3);
      loadY();
      applyStimulus(1, 0, 3, 0);
      applyStimulus(0, 1, -2, 1);
      collectResult(5);
      loadY();
      applyStimulus(1, 1, 4, 1);
      collectResult(0);

      // Empty matrix
      loadY();
      applyStimulus(0, 0, 0, 1);
      collectResult(1);

      // Reset in the middle of accumulation
      setY(10, 20, 30, 40);
      loadY();
      applyStimulus(0, 0, 5, 0);
      applyStimulus(1, 1, 6, 0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midreset_out_valid", bus.out_valid, 0);
      checkOutput("midreset_y_ready", bus.y_ready, 1);
      checkOutput("midreset_x_ready", bus.x_ready, 0);
      rst = 1'b1;
      clearModel();
      setY(2, -1, 1, 3);
      loadY();
      applyStimulus(1, 0, 7, 1);
      collectResult(0);

`ifdef COO_STREAM_BOUNDS_CHECK_EN
      setY(11, -12, 13, 14);
      loadY();
      applyStimulus(5, 0, 7, 0);
      applyStimulus(0, 0, 1, 1);
      collectResult(0);
`else
      $display("[TB] bounds test skipped (COO_STREAM_BOUNDS_CHECK_EN undefined)");
`endif

      // Largest-magnitude products at the nonzero limit
      setY(-128, -128, -128, -128);
      loadY();
      for (int i = 0; i < MAXN; i++)
         applyStimulus(0, 0, -128, i == MAXN - 1);
      collectResult(0);

      // Counter saturation with extra triplets still accumulated
      setY(100, -100, 50, 1);
      loadY();
      for (int i = 0; i < MAXN + 3; i++)
         applyStimulus(i % N, (i / 2) % M, 127 - i, i == MAXN + 2);
      collectResult(2);

      // Random matrices with valid/ready stalls
      stall_en = 1;
      for (int t = 0; t < 200; t++) begin
         int cnt;
         for (int m = 0; m < M; m++)
            for (int k = 0; k < K; k++)
               ym[m][k] = int'($urandom_range(0, 255)) - 128;
         loadY();
         cnt = int'($urandom_range(1, 20));
         for (int j = 0; j < cnt; j++)
            applyStimulus(int'($urandom_range(0, N - 1)), int'($urandom_range(0, M - 1)),
                          int'($urandom_range(0, 255)) - 128, j == cnt - 1);
         collectResult(int'($urandom_range(0, 3)));
      end

      checkOutput("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end
endmodule

// File: doc/coo_stream_matmul.md
Name: coo_stream_matmul

Overview:
- Streaming successor to the fully-parallel COO matmul: computes OUT = X * Y, with X (N x M, sparse) arriving as a stream of COO triplets, one per cycle, and Y (M x K, dense) loaded once per matrix.
- The block holds N*K accumulators and updates all K columns of one output row per accepted nonzero.
- The nonzero count is not fixed: any number up to MAX_NZN per matrix; duplicate coordinates accumulate.
- Sits between the COO encoder/loader and downstream compressed_arithmetic consumers.

Parameters:
- N, 4, rows of X / OUT
- M, 4, cols of X / rows of Y
- K, 4, cols of Y / OUT
- X_WIDTH, 8, signed X element width
- X_FRAC_WIDTH, 1, X fraction bits
- Y_WIDTH, 8, signed Y element width
- Y_FRAC_WIDTH, 1, Y fraction bits
- MAX_NZN, 16, max nonzeros per matrix; sizes accumulators and counter
- ADDR_WIDTH, 16, row/col index width
- OUTPUT_ROUNDING, 1, 1 = fixed_round to OUT format; 0 = raw accumulator (OUT widths must equal ACC widths, else $fatal)
- OUT_WIDTH, 16, output width
- OUT_FRAC_WIDTH, 0, output fraction bits

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- y_data  in  [Y_WIDTH-1:0] x M*K  Y, element (m,k) at index m*K+k
- y_valid  in  1  Y valid
- y_ready  out  1  Y ready
- x_data  in  X_WIDTH  nonzero value
- x_row  in  ADDR_WIDTH  row index
- x_col  in  ADDR_WIDTH  col index
- x_last  in  1  final triplet of the matrix
- x_valid  in  1  triplet valid
- x_ready  out  1  triplet ready
- out_data  out  [OUT_WIDTH-1:0] x N*K  OUT, element (n,k) at n*K+k
- out_nnz  out  $clog2(MAX_NZN+1)  triplets accumulated for this matrix
- out_valid  out  1  result valid
- out_ready  in  1  result ready

Behaviour:
- ACC_WIDTH = X_WIDTH+Y_WIDTH+$clog2(MAX_NZN); ACC_FRAC_WIDTH = X_FRAC_WIDTH+Y_FRAC_WIDTH. All arithmetic signed and sign-extended; accumulators wrap on overflow.
- FSM states: WAIT_Y -> ACCUM -> OUTPUT -> WAIT_Y.
- Reset (rst==0 at posedge): state=WAIT_Y; all accumulators 0; Y register 0; nnz counter 0; out_valid=0, x_ready=0, y_ready=1. Reset mid-matrix discards all partial results.
- WAIT_Y:
  - y_ready=1, x_ready=0.
  - On y_valid&&y_ready: latch Y, go to ACCUM.
- ACCUM:
  - x_ready=1, y_ready=0.
  - On an accepted triplet with x_row<N and x_col<M: acc[x_row][k] += x_data*Y[x_col][k] for all k. The update is registered at that edge.
  - nnz counter increments, saturating at MAX_NZN. Triplets arriving after saturation are still accumulated.
  - Out-of-range triplet: handshake completes, but accumulators and counter are untouched.
  - If x_last is accepted: the triplet is processed normally and the state moves to OUTPUT. out_valid=1 in the following cycle.
  - Empty matrix: send one triplet with x_data=0 and x_last=1; result is all zeros with nnz=1.
- OUTPUT:
  - out_valid=1, x_ready=0, y_ready=0.
  - out_data = rounded (or raw) accumulators; out_nnz = counter. Both held stable while out_valid && !out_ready.
  - On out_ready: clear accumulators and counter, go to WAIT_Y.
- Throughput: 1 triplet/cycle. Per-matrix overhead is 1 cycle for Y load plus 1 cycle for the output handshake.
- x and y are never accepted in the same cycle.

Optional Feature:
- Macro: COO_STREAM_BOUNDS_CHECK_EN.
- Defined: adds output err (1 bit) and a sticky error register.
  - err is set on any out-of-range triplet or any triplet accepted while the counter is at MAX_NZN.
  - err is visible with out_valid and cleared on the output handshake or reset.
  - Out-of-range triplets are dropped, as described above.
- Undefined:
  - No err port and no range comparators.
  - Indices are truncated to $clog2(N)/$clog2(M) bits and always accumulated.
  - Out-of-range input is undefined by contract.

Test Plan:
1. N=M=K=2, OUTPUT_ROUNDING=0. Y=[[1,2],[3,4]]; triplets (0,0,1),(1,1,2,last) -> OUT=[[1,2],[6,8]], nnz=2, out_valid exactly 1 cycle after the last handshake.
2. Duplicates: same Y; (0,1,1),(0,1,1),(0,1,-1,last) -> OUT row0=[3,4], row1=[0,0], nnz=3.
3. Backpressure: hold out_ready=0 for 5 cycles -> out_data stable, x_ready=0 and y_ready=0 throughout. Release -> next cycle y_ready=1 and accumulators are zero (second matrix starts clean).
4. Reset mid-ACCUM after 2 triplets -> out_valid=0, y_ready=1. A new matrix then gives results with no residue from the aborted one.
5. Bounds (macro defined): triplet (5,0,7) then (0,0,1,last) -> OUT[0][*]=Y row0, nnz=1, err=1. With the macro undefined, this test is skipped.
6. Signed/random: x_data=-128, Y=-128, MAX_NZN=16 repeated 16x -> acc=+262144 with no wrap in ACC_WIDTH. Then 200 random matrices checked against the numpy reference with random valid/ready stalls.
